imuldiv_muldiv_arbiter: RTL and testbench

//  Shares one val/rdy muldiv unit (e.g. imuldiv_IntMulIterative) between two requesters.

---
 rtl/imuldiv_muldiv_arbiter_pkg.sv | 32 +++
 rtl/imuldiv_muldiv_tag_queue.sv | 58 +++++
 rtl/imuldiv_muldiv_arbiter.sv | 88 ++++++++
 tb/tb_imuldiv_muldiv_arbiter.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imuldiv_muldiv_arbiter_pkg.sv
// Shared definitions for the muldiv arbiter: message widths, function encodings
// and helpers to build and slice MulDivReqMsg words.
package imuldiv_muldiv_arbiter_pkg;

    localparam int REQ_W  = 67;
    localparam int RESP_W = 64;

    localparam logic [2:0] FUNC_MUL  = 3'd0;
    localparam logic [2:0] FUNC_DIV  = 3'd1;
    localparam logic [2:0] FUNC_DIVU = 3'd2;
    localparam logic [2:0] FUNC_REM  = 3'd3;
    localparam logic [2:0] FUNC_REMU = 3'd4;

    // Request layout: func[66:64], a[63:32], b[31:0]
    function automatic logic [2:0] req_func(input logic [REQ_W-1:0] msg);
        return msg[66:64];
    endfunction

    function automatic logic [31:0] req_a(input logic [REQ_W-1:0] msg);
        return msg[63:32];
    endfunction

    function automatic logic [31:0] req_b(input logic [REQ_W-1:0] msg);
        return msg[31:0];
    endfunction

    function automatic logic [REQ_W-1:0] mk_req(input logic [2:0] func, input logic [31:0] a,
                                                input logic [31:0] b);
        return {func, a, b};
    endfunction

endpackage

// File: rtl/imuldiv_muldiv_tag_queue.sv
// In-order FIFO of 1-bit owner tags, one entry per request in flight at the unit.
// A push into a full queue is accepted only when a pop happens in the same cycle.
module imuldiv_muldiv_tag_queue #(
    parameter int DEPTH = 2,
    localparam int CW = $clog2(DEPTH + 1),
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic          push_tag,
    input  logic          pop,
    output logic [CW-1:0] count,
    output logic          head
);

    logic [DEPTH-1:0] mem;
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic             is_full;
    logic             is_empty;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        if (p == PW'(DEPTH - 1)) return '0;
        return p + PW'(1);
    endfunction

    assign is_full  = (count == CW'(DEPTH));
    assign is_empty = (count == '0);
    assign do_pop   = pop & ~is_empty;
    assign do_push  = push & (~is_full | do_pop);
    assign head     = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem    <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_tag;
                wr_ptr      <= ptr_inc(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/imuldiv_muldiv_arbiter.sv
// Round-robin sharing of one val/rdy muldiv unit between two requesters, with
// responses steered back to their issuer through an in-order owner tag queue.
module imuldiv_muldiv_arbiter
    import imuldiv_muldiv_arbiter_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic              clk,
    input  logic              reset,

    input  logic [REQ_W-1:0]  req0_msg,
    input  logic              req0_val,
    output logic              req0_rdy,
    output logic [RESP_W-1:0] resp0_msg,
    output logic              resp0_val,
    input  logic              resp0_rdy,

    input  logic [REQ_W-1:0]  req1_msg,
    input  logic              req1_val,
    output logic              req1_rdy,
    output logic [RESP_W-1:0] resp1_msg,
    output logic              resp1_val,
    input  logic              resp1_rdy,

    output logic [REQ_W-1:0]  unit_req_msg,
    output logic              unit_req_val,
    input  logic              unit_req_rdy,
    input  logic [RESP_W-1:0] unit_resp_msg,
    input  logic              unit_resp_val,
    output logic              unit_resp_rdy
);

    localparam int CW = $clog2(DEPTH + 1);

    // Handshake rule on every port: a transfer happens on a rising edge where
    // val and rdy are both 1; rdy never waits on val beyond winner selection.

    logic          prio;
    logic          winner;
    logic          any_val;
    logic          space;
    logic          can_issue;
    logic          fire;
    logic          pop;
    logic          has_tag;
    logic          head;
    logic [CW-1:0] count;

    always_comb begin
        winner = req1_val;
        if (req0_val & req1_val) winner = prio;
    end

    assign any_val   = req0_val | req1_val;
    assign pop       = unit_resp_val & unit_resp_rdy;
    assign space     = (count != CW'(DEPTH)) | pop;
    assign can_issue = reset & unit_req_rdy & space;

    assign unit_req_val = reset & any_val & space;
    assign unit_req_msg = winner ? req1_msg : req0_msg;
    assign req0_rdy     = can_issue & ~winner;
    assign req1_rdy     = can_issue & winner;
    assign fire         = unit_req_val & unit_req_rdy;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) prio <= 1'b0;
        else if (fire) prio <= ~winner;
    end

    imuldiv_muldiv_tag_queue #(.DEPTH(DEPTH)) u_tag_queue (
        .clk      (clk),
        .rst_n    (reset),
        .push     (fire),
        .push_tag (winner),
        .pop      (pop),
        .count    (count),
        .head     (head)
    );

    // A unit response arriving with no tag outstanding has no owner and is left unaccepted.
    assign has_tag       = reset & (count != '0);
    assign resp0_val     = unit_resp_val & has_tag & ~head;
    assign resp1_val     = unit_resp_val & has_tag & head;
    assign resp0_msg     = unit_resp_msg;
    assign resp1_msg     = unit_resp_msg;
    assign unit_resp_rdy = has_tag & (head ? resp1_rdy : resp0_rdy);

endmodule

// File: tb/tb_imuldiv_muldiv_arbiter.sv
// Bench for imuldiv_muldiv_arbiter: directed multiply vectors on two requesters,
// a behavioural in-order signed multiplier as the shared unit, and per-port scoreboards.
module tb_imuldiv_muldiv_arbiter;
    import imuldiv_muldiv_arbiter_pkg::*;

    localparam int DEPTH = 2;
    localparam int LAT   = 3;
    localparam int UCAP  = 4;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic [REQ_W-1:0]  req0_msg, req1_msg, unit_req_msg;
    logic              req0_val, req0_rdy, req1_val, req1_rdy;
    logic [RESP_W-1:0] resp0_msg, resp1_msg, unit_resp_msg;
    logic              resp0_val, resp0_rdy, resp1_val, resp1_rdy;
    logic              unit_req_val, unit_req_rdy, unit_resp_val, unit_resp_rdy;

    imuldiv_muldiv_arbiter #(.DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .req0_msg(req0_msg), .req0_val(req0_val), .req0_rdy(req0_rdy),
        .resp0_msg(resp0_msg), .resp0_val(resp0_val), .resp0_rdy(resp0_rdy),
        .req1_msg(req1_msg), .req1_val(req1_val), .req1_rdy(req1_rdy),
        .resp1_msg(resp1_msg), .resp1_val(resp1_val), .resp1_rdy(resp1_rdy),
        .unit_req_msg(unit_req_msg), .unit_req_val(unit_req_val), .unit_req_rdy(unit_req_rdy),
        .unit_resp_msg(unit_resp_msg), .unit_resp_val(unit_resp_val), .unit_resp_rdy(unit_resp_rdy)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- shared state ----------------
    int total = 0;
    int bad = 0;
    logic [REQ_W-1:0]  s0_q[$], s1_q[$];
    logic [RESP_W-1:0] exp0_q[$], exp1_q[$];
    logic              grant_q[$];
    logic              hold0 = 1'b0;
    logic              rand_rdy = 1'b0;
    logic              stub_on = 1'b0;
    logic              watch_on = 1'b0;
    logic              r1_watch = 1'b0;
    int                r1_seen = 0;
    int                viol_rdy = 0;
    int                full_bad = 0;
    int                max_cnt = 0;
    int                swap_seen = 0;
    logic              swap_pend = 1'b0;
    logic              swap_tag = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic slot();
        @(posedge clk);
        #3;
    endtask

    task automatic send0(input logic [31:0] a, input logic [31:0] b, input logic [63:0] exp);
        s0_q.push_back(mk_req(FUNC_MUL, a, b));
        exp0_q.push_back(exp);
    endtask

    task automatic send1(input logic [31:0] a, input logic [31:0] b, input logic [63:0] exp);
        s1_q.push_back(mk_req(FUNC_MUL, a, b));
        exp1_q.push_back(exp);
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n;
        n = 0;
        while ((s0_q.size() + s1_q.size() + exp0_q.size() + exp1_q.size()) != 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        #3;
        total++;
        if (n >= budget) begin
            bad++;
            $display("FAIL %s: drain timed out, pending=%0d required=0", name,
                     s0_q.size() + s1_q.size() + exp0_q.size() + exp1_q.size());
        end
    endtask

    function automatic logic [63:0] unit_mul(input logic [REQ_W-1:0] m);
        logic signed [63:0] x;
        logic signed [63:0] y;
        x = 64'($signed(req_a(m)));
        y = 64'($signed(req_b(m)));
        return 64'(x * y);
    endfunction

    // ---------------- requester drivers ----------------
    initial begin
        logic t;
        req0_val = 1'b0;
        req0_msg = '0;
        forever begin
            @(negedge clk);
            t = req0_val & req0_rdy;
            @(posedge clk);
            #1;
            if (t && s0_q.size() > 0) void'(s0_q.pop_front());
            req0_val = (s0_q.size() > 0);
            req0_msg = (s0_q.size() > 0) ? s0_q[0] : '0;
        end
    end

    initial begin
        logic t;
        req1_val = 1'b0;
        req1_msg = '0;
        forever begin
            @(negedge clk);
            t = req1_val & req1_rdy;
            @(posedge clk);
            #1;
            if (t && s1_q.size() > 0) void'(s1_q.pop_front());
            req1_val = (s1_q.size() > 0);
            req1_msg = (s1_q.size() > 0) ? s1_q[0] : '0;
        end
    end

    initial begin
        resp0_rdy = 1'b0;
        resp1_rdy = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            resp0_rdy = hold0 ? 1'b0 : (rand_rdy ? ($urandom_range(0, 3) != 0) : 1'b1);
            resp1_rdy = rand_rdy ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
    end

    // ---------------- shared unit model ----------------
    logic [63:0] u_res[$];
    int          u_age[$];

    initial begin
        logic             tr;
        logic             tp;
        logic [REQ_W-1:0] m;
        unit_req_rdy  = 1'b0;
        unit_resp_val = 1'b0;
        unit_resp_msg = '0;
        forever begin
            @(negedge clk);
            tr = unit_req_val & unit_req_rdy;
            tp = unit_resp_val & unit_resp_rdy;
            m  = unit_req_msg;
            @(posedge clk);
            #1;
            if (!reset) begin
                u_res.delete();
                u_age.delete();
            end else begin
                if (tp && !stub_on && u_res.size() > 0) begin
                    void'(u_res.pop_front());
                    void'(u_age.pop_front());
                end
                foreach (u_age[i]) u_age[i]++;
                if (tr) begin
                    u_res.push_back(unit_mul(m));
                    u_age.push_back(0);
                end
            end
            unit_req_rdy  = reset && (u_res.size() < UCAP);
            unit_resp_val = 1'b0;
            unit_resp_msg = '0;
            if (u_res.size() > 0) begin
                unit_resp_msg = u_res[0];
                if (u_age[0] >= LAT) unit_resp_val = 1'b1;
            end
            if (stub_on) begin
                unit_resp_val = 1'b1;
                unit_resp_msg = 64'hdead_beef_0bad_f00d;
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        int cnt;
        if (reset) begin
            cnt = int'(dut.u_tag_queue.count);
            if (resp0_val && resp0_rdy) begin
                if (exp0_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL resp0_unexpected: got %h expected no response", resp0_msg);
                end else begin
                    check("resp0_msg", resp0_msg, exp0_q.pop_front());
                end
            end
            if (resp1_val && resp1_rdy) begin
                if (exp1_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL resp1_unexpected: got %h expected no response", resp1_msg);
                end else begin
                    check("resp1_msg", resp1_msg, exp1_q.pop_front());
                end
            end
            if (r1_watch && resp1_val) r1_seen++;
            if (unit_req_val && unit_req_rdy) grant_q.push_back(req1_val & req1_rdy);
            if (watch_on) begin
                if (unit_resp_rdy) viol_rdy++;
                if (cnt > max_cnt) max_cnt = cnt;
                if (cnt == DEPTH && !(unit_resp_val && unit_resp_rdy) && (req0_rdy || req1_rdy))
                    full_bad++;
            end
            if (swap_pend) begin
                swap_pend = 1'b0;
                check("swap_count", 64'(cnt), 64'(DEPTH));
                check("swap_tail_tag",
                      64'(dut.u_tag_queue.mem[dut.u_tag_queue.wr_ptr - 1'b1]), 64'(swap_tag));
            end
            if (cnt == DEPTH && unit_resp_val && unit_resp_rdy && unit_req_val && unit_req_rdy) begin
                swap_seen++;
                swap_pend = 1'b1;
                swap_tag  = req1_val & req1_rdy;
            end
        end
    end

    // ---------------- directed sequence ----------------
    initial begin
        reset = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_req0_rdy", 64'(req0_rdy), 64'd0);
        check("rst_req1_rdy", 64'(req1_rdy), 64'd0);
        check("rst_unit_req_val", 64'(unit_req_val), 64'd0);
        check("rst_unit_resp_rdy", 64'(unit_resp_rdy), 64'd0);
        check("rst_resp_val", 64'({resp0_val, resp1_val}), 64'd0);
        check("rst_count", 64'(dut.u_tag_queue.count), 64'd0);
        check("rst_prio", 64'(dut.prio), 64'd0);
        slot();
        reset = 1'b1;
        slot();

        // Both requesters valid every cycle: grants alternate starting with 0
        grant_q.delete();
        send0(32'h0000_0001, 32'h0000_0001, 64'h0000_0000_0000_0001);
        send0(32'h0000_0008, 32'h0000_0003, 64'h0000_0000_0000_0018);
        send1(32'hffff_ffff, 32'h0000_0001, 64'hffff_ffff_ffff_ffff);
        send1(32'hffff_fff8, 32'h0000_0008, 64'hffff_ffff_ffff_ffc0);
        wait_drain("fair_drain", 200);
        check("grant_count", 64'(grant_q.size()), 64'd4);
        if (grant_q.size() >= 4) begin
            check("grant0", 64'(grant_q[0]), 64'd0);
            check("grant1", 64'(grant_q[1]), 64'd1);
            check("grant2", 64'(grant_q[2]), 64'd0);
            check("grant3", 64'(grant_q[3]), 64'd1);
        end

        // Only requester 0 active
        r1_watch = 1'b1;
        send0(32'h0000_0008, 32'h0000_0003, 64'h0000_0000_0000_0018);
        wait_drain("solo_drain", 100);
        repeat (3) slot();
        r1_watch = 1'b0;
        check("solo_resp1_val", 64'(r1_seen), 64'd0);

        // Requester 0 stalls its response while requester 1 streams
        hold0 = 1'b1;
        send0(32'h0000_0007, 32'h0000_0006, 64'h0000_0000_0000_002a);
        send0(32'h1234_5678, 32'h0000_0010, 64'h0000_0001_2345_6780);
        repeat (3) slot();
        send1(32'h0000_0002, 32'h0000_0003, 64'h0000_0000_0000_0006);
        send1(32'h0000_0010, 32'h0000_0010, 64'h0000_0000_0000_0100);
        send1(32'hffff_ffff, 32'hffff_ffff, 64'h0000_0000_0000_0001);
        send1(32'h7fff_ffff, 32'h0000_0002, 64'h0000_0000_ffff_fffe);
        send1(32'h8000_0000, 32'h0000_0002, 64'hffff_ffff_0000_0000);
        send1(32'h0000_0005, 32'hffff_fffd, 64'hffff_ffff_ffff_fff1);
        watch_on = 1'b1;
        repeat (50) slot();
        watch_on = 1'b0;
        check("hold_unit_resp_rdy", 64'(viol_rdy), 64'd0);
        check("hold_max_count", 64'(max_cnt), 64'(DEPTH));
        check("hold_full_rdy", 64'(full_bad), 64'd0);
        hold0 = 1'b0;
        wait_drain("hold_drain", 300);
        check("full_swap_seen", 64'(swap_seen != 0), 64'd1);

        // Mixed traffic with random response back-pressure
        rand_rdy = 1'b1;
        send0(32'h0001_0000, 32'h0001_0000, 64'h0000_0001_0000_0000);
        send0(32'hffff_fffd, 32'hffff_fffb, 64'h0000_0000_0000_000f);
        send1(32'h0000_0100, 32'hffff_ff00, 64'hffff_ffff_ffff_0000);
        send1(32'd1000, 32'd1000, 64'h0000_0000_000f_4240);
        wait_drain("rand_drain", 400);
        rand_rdy = 1'b0;
        repeat (2) slot();

        // Unit response with no tag outstanding is not accepted or steered
        stub_on = 1'b1;
        slot();
        @(negedge clk);
        check("stub_unit_resp_rdy", 64'(unit_resp_rdy), 64'd0);
        check("stub_resp0_val", 64'(resp0_val), 64'd0);
        check("stub_resp1_val", 64'(resp1_val), 64'd0);
        slot();
        stub_on = 1'b0;
        repeat (2) slot();

        // Reset in the middle of outstanding work
        hold0 = 1'b1;
        send0(32'h0000_0003, 32'h0000_0003, 64'h0000_0000_0000_0009);
        send0(32'h0000_0004, 32'h0000_0004, 64'h0000_0000_0000_0010);
        send0(32'h0000_0005, 32'h0000_0005, 64'h0000_0000_0000_0019);
        repeat (10) slot();
        check("mid_count_before", 64'(dut.u_tag_queue.count), 64'(DEPTH));
        reset = 1'b0;
        s0_q.delete();
        s1_q.delete();
        exp0_q.delete();
        exp1_q.delete();
        hold0 = 1'b0;
        #1;
        check("mid_req0_rdy", 64'(req0_rdy), 64'd0);
        check("mid_unit_req_val", 64'(unit_req_val), 64'd0);
        check("mid_unit_resp_rdy", 64'(unit_resp_rdy), 64'd0);
        check("mid_resp_val", 64'({resp0_val, resp1_val}), 64'd0);
        check("mid_count", 64'(dut.u_tag_queue.count), 64'd0);
        check("mid_prio", 64'(dut.prio), 64'd0);
        repeat (3) slot();
        reset = 1'b1;
        slot();
        send1(32'hffff_fff8, 32'hffff_fff8, 64'h0000_0000_0000_0040);
        wait_drain("post_reset_drain", 100);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
